// File: rtl/clk_slot_sched.sv
// Eight-slot rotating frame scheduler: issues one-cycle per-stage enable strobes
// in programmable slots, with start, frame-boundary halt, stall freeze and shadowed config.
module clk_slot_sched #(
  parameter int NSTAGE = 4,
  parameter int SLOT_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              halt_req,
  input  logic              stall,
  input  logic              cfg_we,
  input  logic [1:0]        cfg_sel,
  input  logic [SLOT_W-1:0] cfg_slot,
  output logic [NSTAGE-1:0] en_out,
  output logic [SLOT_W-1:0] slot,
  output logic              frame_start,
  output logic              running,
  output logic              halted,
  output logic              cfg_pend
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_DRAIN  = 2'd2,
    S_HALTED = 2'd3
  } state_t;

  typedef logic [NSTAGE-1:0][SLOT_W-1:0] cfg_t;

  state_t            r_state, w_state_nx;
  logic [SLOT_W-1:0] r_slot, w_slot_nx;
  logic [NSTAGE-1:0] r_en, w_en_nx;
  logic              r_fs, w_fs_nx;
  logic              r_running, w_running_nx;
  logic              r_halted, w_halted_nx;
  logic              r_pend, w_pend_nx;
  cfg_t              r_active, w_active_nx;
  cfg_t              r_shadow, w_shadow_nx;
  logic [SLOT_W-1:0] w_next_slot;
  logic              w_wrap;

  assign w_next_slot = r_slot + 1'b1;
  assign w_wrap      = (w_next_slot == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx   = r_state;
    w_slot_nx    = r_slot;
    w_en_nx      = r_en;
    w_fs_nx      = r_fs;
    w_running_nx = r_running;
    w_halted_nx  = r_halted;
    w_pend_nx    = r_pend;
    w_active_nx  = r_active;
    w_shadow_nx  = r_shadow;

    case (r_state)
      S_IDLE, S_HALTED: begin
        w_slot_nx = '0;
        w_en_nx   = '0;
        w_fs_nx   = 1'b0;
        if (start) begin
          w_state_nx   = S_RUN;
          w_fs_nx      = 1'b1;
          w_running_nx = 1'b1;
          w_halted_nx  = 1'b0;
          for (int i = 0; i < NSTAGE; i++) w_en_nx[i] = (r_active[i] == '0);
        end
        // While stopped there is no frame in flight, so writes go live at once.
        if (cfg_we) begin
          w_active_nx[cfg_sel] = cfg_slot;
          w_shadow_nx[cfg_sel] = cfg_slot;
        end
      end

      S_RUN, S_DRAIN: begin
        if (stall) begin
          w_en_nx = '0;
          w_fs_nx = 1'b0;
        end else if (w_wrap) begin
          w_active_nx = r_shadow;
          w_pend_nx   = 1'b0;
          w_slot_nx   = '0;
          if (r_state == S_DRAIN) begin
            w_state_nx   = S_HALTED;
            w_en_nx      = '0;
            w_fs_nx      = 1'b0;
            w_running_nx = 1'b0;
            w_halted_nx  = 1'b1;
          end else begin
            w_fs_nx = 1'b1;
            for (int i = 0; i < NSTAGE; i++) w_en_nx[i] = (r_shadow[i] == '0);
          end
        end else begin
          w_slot_nx = w_next_slot;
          w_fs_nx   = 1'b0;
          for (int i = 0; i < NSTAGE; i++) w_en_nx[i] = (r_active[i] == w_next_slot);
        end

        if ((r_state == S_RUN) && halt_req) w_state_nx = S_DRAIN;

        // A write on a load edge lands after the load, leaving the update pending.
        if (cfg_we) begin
          w_shadow_nx[cfg_sel] = cfg_slot;
          w_pend_nx            = 1'b1;
        end
      end

      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_slot    <= '0;
      r_en      <= '0;
      r_fs      <= 1'b0;
      r_running <= 1'b0;
      r_halted  <= 1'b0;
      r_pend    <= 1'b0;
      for (int i = 0; i < NSTAGE; i++) begin
        r_active[i] <= SLOT_W'(2 * i);
        r_shadow[i] <= SLOT_W'(2 * i);
      end
    end else begin
      r_slot    <= w_slot_nx;
      r_en      <= w_en_nx;
      r_fs      <= w_fs_nx;
      r_running <= w_running_nx;
      r_halted  <= w_halted_nx;
      r_pend    <= w_pend_nx;
      r_active  <= w_active_nx;
      r_shadow  <= w_shadow_nx;
    end
  end

  assign en_out      = r_en;
  assign slot        = r_slot;
  assign frame_start = r_fs;
  assign running     = r_running;
  assign halted      = r_halted;
  assign cfg_pend    = r_pend;

endmodule

// File: tb/tb_clk_slot_sched.sv
// Bench for clk_slot_sched: directed frame scenarios and random traffic, each cycle
// checked against a frame-level reference model of the scheduler.
module tb_clk_slot_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, halt_req, stall, cfg_we;
  logic [1:0] cfg_sel;
  logic [2:0] cfg_slot;
  logic [3:0] en_out;
  logic [2:0] slot;
  logic       frame_start, running, halted, cfg_pend;

  int total = 0;
  int bad   = 0;

  clk_slot_sched #(.NSTAGE(4), .SLOT_W(3)) dut (
    .clk(clk), .rst(rst), .start(start), .halt_req(halt_req), .stall(stall),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_slot(cfg_slot),
    .en_out(en_out), .slot(slot), .frame_start(frame_start),
    .running(running), .halted(halted), .cfg_pend(cfg_pend)
  );

  always #5 clk = ~clk;

  // Reference model: mode 0=idle 1=run 2=drain 3=halted
  int   m_mode, m_slot;
  int   act[4], sh[4];
  logic [3:0] m_en;
  logic m_fs, m_run, m_halt, m_pend;
  int   st1_cnt;

  function automatic logic [3:0] fire_mask(input int pos);
    logic [3:0] m = '0;
    for (int i = 0; i < 4; i++) if (act[i] == pos) m[i] = 1'b1;
    return m;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_slot = 0; m_en = '0; m_fs = 0; m_run = 0; m_halt = 0; m_pend = 0;
    for (int i = 0; i < 4; i++) begin act[i] = 2 * i; sh[i] = 2 * i; end
  endtask

  task automatic model_step();
    int orig = m_mode;
    if (orig == 0 || orig == 3) begin
      m_slot = 0; m_en = '0; m_fs = 0;
      if (start) begin
        m_mode = 1; m_fs = 1; m_run = 1; m_halt = 0; m_en = fire_mask(0);
      end
      if (cfg_we) begin act[cfg_sel] = cfg_slot; sh[cfg_sel] = cfg_slot; end
    end else begin
      if (stall) begin
        m_en = '0; m_fs = 0;
      end else if ((m_slot + 1) % 8 == 0) begin
        for (int i = 0; i < 4; i++) act[i] = sh[i];
        m_pend = 0; m_slot = 0;
        if (orig == 2) begin
          m_mode = 3; m_en = '0; m_fs = 0; m_run = 0; m_halt = 1;
        end else begin
          m_fs = 1; m_en = fire_mask(0);
        end
      end else begin
        m_slot = m_slot + 1; m_fs = 0; m_en = fire_mask(m_slot);
      end
      if (orig == 1 && halt_req) m_mode = 2;
      if (cfg_we) begin sh[cfg_sel] = cfg_slot; m_pend = 1; end
    end
  endtask

  task automatic chk(input string tag, input int got, input int want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, want);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".slot"}, int'(slot), m_slot);
    chk({tag, ".en"}, int'(en_out), int'(m_en));
    chk({tag, ".fs"}, int'(frame_start), int'(m_fs));
    chk({tag, ".run"}, int'(running), int'(m_run));
    chk({tag, ".halt"}, int'(halted), int'(m_halt));
    chk({tag, ".pend"}, int'(cfg_pend), int'(m_pend));
  endtask

  task automatic tick(input string tag);
    model_step();
    @(posedge clk);
    #1;
    chk_all(tag);
    st1_cnt = frame_start ? int'(en_out[1]) : st1_cnt + int'(en_out[1]);
  endtask

  task automatic clear_in();
    start = 0; halt_req = 0; stall = 0; cfg_we = 0; cfg_sel = 0; cfg_slot = 0;
  endtask

  task automatic run_to_slot(input int s, input string tag);
    bit hit = 0;
    for (int k = 0; k < 20 && !hit; k++) begin
      if (int'(slot) == s && running) hit = 1;
      else tick(tag);
    end
    total++;
    assert (hit) else begin
      bad++;
      $error("FAIL %s: reach slot observed=%0d expected=%0d", tag, slot, s);
    end
  endtask

  task automatic run_to_halt(input string tag);
    bit hit = 0;
    for (int k = 0; k < 20 && !hit; k++) begin
      if (halted) hit = 1;
      else tick(tag);
    end
    total++;
    assert (hit) else begin
      bad++;
      $error("FAIL %s: halted observed=%0d expected=1", tag, halted);
    end
  endtask

  initial begin
    logic [3:0] dflt [8];
    dflt = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000};
    st1_cnt = 0;
    clear_in();
    rst = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset");
    rst = 1;
    tick("idle");

    // default frame
    start = 1;
    tick("start");
    start = 0;
    chk("dflt.slot0.en", int'(en_out), 1);
    for (int k = 0; k < 18; k++) begin
      tick("dflt");
      chk("dflt.table", int'(en_out), int'(dflt[slot]));
      chk("dflt.fs", int'(frame_start), int'(slot == 0));
    end
    run_to_slot(2, "to_s2");

    // stall at slot 2
    stall = 1;
    for (int k = 0; k < 3; k++) begin
      tick("stall");
      chk("stall.slot", int'(slot), 2);
      chk("stall.en", int'(en_out), 0);
    end
    stall = 0;
    tick("unstall");
    chk("unstall.slot", int'(slot), 3);
    chk("stage1.once", st1_cnt, 1);

    // reconfig stage 3 to slot 1 during slot 4
    run_to_slot(4, "to_s4");
    cfg_we = 1; cfg_sel = 3; cfg_slot = 1;
    tick("cfg");
    clear_in();
    chk("cfg.pend", int'(cfg_pend), 1);
    tick("cfg.s6");
    chk("cfg.old_s6", int'(en_out[3]), 1);
    tick("cfg.s7");
    tick("cfg.s0");
    chk("cfg.pend_clr", int'(cfg_pend), 0);
    tick("cfg.s1");
    chk("cfg.new_s1", int'(en_out), 4'b1000);

    // halt at slot 3
    run_to_slot(3, "to_s3");
    halt_req = 1;
    tick("halt_req");
    halt_req = 0;
    run_to_halt("drain");
    chk("halt.halted", int'(halted), 1);
    chk("halt.running", int'(running), 0);
    chk("halt.slot", int'(slot), 0);
    chk("halt.en", int'(en_out), 0);
    tick("halted");
    start = 1;
    tick("restart");
    start = 0;
    chk("restart.slot", int'(slot), 0);
    chk("restart.run", int'(running), 1);

    // stop again, then write stages 0 and 2 to slot 5 while stopped
    halt_req = 1;
    tick("halt2");
    halt_req = 0;
    run_to_halt("drain2");
    cfg_we = 1; cfg_sel = 0; cfg_slot = 5;
    tick("icfg0");
    chk("icfg0.pend", int'(cfg_pend), 0);
    cfg_sel = 2;
    tick("icfg2");
    chk("icfg2.pend", int'(cfg_pend), 0);
    clear_in();
    start = 1;
    tick("istart");
    start = 0;
    for (int k = 0; k < 5; k++) begin
      tick("irun");
      chk("irun.pend", int'(cfg_pend), 0);
    end
    chk("irun.s5", int'(en_out), 4'b0101);

    // asynchronous reset mid-frame at slot 5
    #2;
    rst = 0;
    #1;
    chk("areset.slot", int'(slot), 0);
    chk("areset.en", int'(en_out), 0);
    chk("areset.run", int'(running), 0);
    chk("areset.pend", int'(cfg_pend), 0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1;
    start = 1;
    tick("rstart");
    start = 0;
    for (int k = 0; k < 8; k++) begin
      tick("rcfg");
      chk("rcfg.table", int'(en_out), int'(dflt[slot]));
    end

    // random traffic against the model
    for (int k = 0; k < 600; k++) begin
      start    = ($urandom_range(7) == 0);
      halt_req = ($urandom_range(15) == 0);
      stall    = ($urandom_range(3) == 0);
      cfg_we   = ($urandom_range(5) == 0);
      cfg_sel  = 2'($urandom_range(3));
      cfg_slot = 3'($urandom_range(7));
      tick("rand");
    end
    clear_in();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clk_slot_sched.md
Name: clk_slot_sched

Overview:
- Frame scheduler for the multi-cycle processor.
- Runs an 8-slot rotating frame and issues one-cycle enable strobes to each datapath stage (PC update, instruction memory, register file, data memory) in a programmable slot.
- Supports start, halt at a frame boundary, a stall freeze, and slot reconfiguration that takes effect at the next frame boundary.
- Strobes are synchronous enables, never gated clocks; downstream stages use them as clock enables on clk.

Parameters:
NSTAGE, 4, number of stage enable outputs (stage 0 = PC, 1 = imem, 2 = regfile, 3 = dmem)
SLOT_W, 3, slot index width; frame length = 2**SLOT_W slots

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous, active-low reset
start  input  1  begin running frames (sampled in IDLE/HALTED)
halt_req  input  1  finish the current frame, then stop
stall  input  1  freeze slot counter, suppress strobes
cfg_we  input  1  slot-assignment write strobe
cfg_sel  input  2  stage index being configured
cfg_slot  input  SLOT_W  slot number assigned to stage cfg_sel
en_out  output  NSTAGE  per-stage one-cycle enable strobes
slot  output  SLOT_W  current slot index
frame_start  output  1  high during slot 0 of each frame
running  output  1  high in RUN or DRAIN
halted  output  1  high in HALTED
cfg_pend  output  1  shadow config differs from active, waiting for boundary

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, slot=0, en_out=0, frame_start=0, running=0, halted=0, cfg_pend=0.
  - active[i] = shadow[i] = 2*i, giving slots 0, 2, 4, 6.
- All outputs are registered; slot and en_out are always mutually aligned.
- States: IDLE, RUN, DRAIN, HALTED.
- IDLE/HALTED:
  - Outputs held at 0; slot=0.
  - cfg_we writes active[cfg_sel] and shadow[cfg_sel] directly; cfg_pend stays 0.
  - On start=1: next state RUN, slot<=0, en_out[i]<=(active[i]==0), frame_start<=1, running<=1, halted<=0.
- RUN, stall=0:
  - next = slot+1 modulo 2**SLOT_W (7 wraps to 0).
  - slot<=next.
  - frame_start<=(next==0).
  - en_out[i]<=(next==sel[i]), where sel = shadow if next==0 else active.
  - When next==0, active<=shadow and cfg_pend<=0.
- RUN/DRAIN, stall=1:
  - slot holds; en_out<=0; frame_start<=0; no config load.
  - Strobes resume on the first unstalled edge with the incremented slot.
  - Stalling never causes a strobe to be repeated or skipped for a slot.
- Config writes during RUN/DRAIN:
  - cfg_we writes shadow[cfg_sel]; cfg_pend<=1.
  - If the write coincides with a frame-load edge, the load uses the pre-write shadow and cfg_pend remains 1.
- Multiple stages may share a slot; all of their en_out bits assert together.
- halt_req in RUN: next state DRAIN, which behaves exactly as RUN until the wrap edge (next==0).
  - On that edge: state<=HALTED, slot<=0, en_out<=0, frame_start<=0, running<=0, halted<=1, and the pending config is loaded.
- halt_req and start asserted together in RUN: halt wins. start is ignored in RUN/DRAIN. halt_req is ignored in IDLE/HALTED/DRAIN.
- Reset asserted mid-frame: immediate return to reset values; shadow config is lost.

Test Plan:
- Reset, then start pulse with default config -> en_out = 0001, 0000, 0010, 0000, 0100, 0000, 1000, 0000 over slots 0-7, repeating; frame_start high every 8th cycle.
- stall=1 for 3 cycles while slot=2 -> slot stays 2, en_out=0 during stall; next edge gives slot=3, and stage 1 has strobed exactly once this frame.
- In RUN, write cfg_sel=3, cfg_slot=1 during slot 4 -> cfg_pend=1, stage 3 still strobes at slot 6; next frame stage 3 strobes at slot 1 and cfg_pend=0.
- halt_req at slot 3 -> strobes continue through slot 7; then halted=1, running=0, slot=0, en_out=0; a later start restarts at slot 0.
- Config write to stages 0 and 2 both at slot 5 while IDLE -> after start, en_out=0101 at slot 5; cfg_pend never asserts.
- rst low asynchronously at slot 5 mid-frame -> all outputs clear without a clock edge; config returns to slots 0/2/4/6.
